// File: rtl/microsequencer.sv
// Microsequencer: selects the next control-store address from the current
// control word. Supports increment, jump, decode dispatch, conditional
// branch, MOC wait with timeout, and a single-level call/return.
module microsequencer #(
    parameter int                ADDR_W        = 10,
    parameter logic [ADDR_W-1:0] FETCH_STATE   = 10'd1,
    parameter logic [ADDR_W-1:0] TIMEOUT_STATE = 10'd43,
    parameter logic [7:0]        MOC_TIMEOUT   = 8'd255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        ns_sel,
    input  logic [1:0]        cond_sel,
    input  logic              inv,
    input  logic [ADDR_W-1:0] cr_addr,
    input  logic [ADDR_W-1:0] decode_state,
    input  logic              cond_in,
    input  logic              moc,
    input  logic              irq,
    input  logic              stall,
    output logic [ADDR_W-1:0] next_state,
    output logic              mem_timeout
);

    typedef enum logic [2:0] {
        NS_INC     = 3'b000,
        NS_JUMP    = 3'b001,
        NS_DECODE  = 3'b010,
        NS_COND    = 3'b011,
        NS_WAITMOC = 3'b100,
        NS_CALL    = 3'b101,
        NS_RET     = 3'b110,
        NS_FETCH   = 3'b111
    } ns_sel_e;

    logic [ADDR_W-1:0] r_state;
    logic [ADDR_W-1:0] r_ret;
    logic [7:0]        r_wait_cnt;
    logic              r_mem_timeout;

    logic [ADDR_W-1:0] w_inc;
    logic              w_cond;
    logic              w_taken;
    logic [ADDR_W-1:0] w_next;
    logic [ADDR_W-1:0] w_ret_next;
    logic [7:0]        w_cnt_next;
    logic              w_timeout_hit;

    assign w_inc = r_state + ADDR_W'(1);

    // Condition source mux and polarity inversion.
    always_comb begin
        w_cond = 1'b1;
        unique case (cond_sel)
            2'b00:   w_cond = cond_in;
            2'b01:   w_cond = moc;
            2'b10:   w_cond = irq;
            default: w_cond = 1'b1;
        endcase
        w_taken = w_cond ^ inv;
    end

    // Next-address, return-address and wait-counter selection.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // branch can leave a value unassigned and infer a latch.
        w_next        = w_inc;
        w_ret_next    = r_ret;
        w_cnt_next    = '0;
        w_timeout_hit = 1'b0;
        unique case (ns_sel_e'(ns_sel))
            NS_INC:    w_next = w_inc;
            NS_JUMP:   w_next = cr_addr;
            NS_DECODE: w_next = decode_state;
            NS_COND:   w_next = w_taken ? cr_addr : w_inc;
            NS_WAITMOC: begin
                if (moc) begin
                    w_next = w_inc;
                end else if (r_wait_cnt == MOC_TIMEOUT) begin
                    w_next        = TIMEOUT_STATE;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_next     = r_state;
                    w_cnt_next = r_wait_cnt + 8'd1;
                end
            end
            NS_CALL: begin
                w_next     = cr_addr;
                w_ret_next = w_inc;
            end
            NS_RET:    w_next = r_ret;
            NS_FETCH:  w_next = FETCH_STATE;
            default:   w_next = w_inc;
        endcase
    end

    // Sequencer state update; stall freezes everything, reset clears it all.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            r_state       <= '0;
            r_ret         <= '0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else if (!stall) begin
            r_state    <= w_next;
            r_ret      <= w_ret_next;
            r_wait_cnt <= w_cnt_next;
            if (w_timeout_hit) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign next_state  = r_state;
    assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed scenarios followed by
// randomized control words, all checked against a behavioural model.
module tb_microsequencer;

    localparam int AW  = 10;
    localparam int MOD = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    ns_sel;
    logic [1:0]    cond_sel;
    logic          inv;
    logic [AW-1:0] cr_addr;
    logic [AW-1:0] decode_state;
    logic          cond_in;
    logic          moc;
    logic          irq;
    logic          stall;
    logic [AW-1:0] next_state;
    logic          mem_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: address, return address, consecutive
    // unsatisfied wait cycles, and the sticky timeout flag.
    int m_state;
    int m_ret;
    int m_wait;
    int m_to;

    microsequencer dut (
        .clk          (clk),
        .reset        (reset),
        .ns_sel       (ns_sel),
        .cond_sel     (cond_sel),
        .inv          (inv),
        .cr_addr      (cr_addr),
        .decode_state (decode_state),
        .cond_in      (cond_in),
        .moc          (moc),
        .irq          (irq),
        .stall        (stall),
        .next_state   (next_state),
        .mem_timeout  (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ret   = 0;
        m_wait  = 0;
        m_to    = 0;
    endtask

    // Behavioural outcome of one clock edge, from the current inputs.
    task automatic model_edge();
        int  inc;
        int  nxt;
        bit  c;
        if (stall) return;
        inc = (m_state + 1) % MOD;
        nxt = inc;
        case (int'(ns_sel))
            0: nxt = inc;
            1: nxt = int'(cr_addr);
            2: nxt = int'(decode_state);
            3: begin
                case (int'(cond_sel))
                    0: c = cond_in;
                    1: c = moc;
                    2: c = irq;
                    default: c = 1'b1;
                endcase
                nxt = ((c ^ inv) == 1'b1) ? int'(cr_addr) : inc;
            end
            4: ;
            5: begin
                nxt   = int'(cr_addr);
                m_ret = inc;
            end
            6: nxt = m_ret;
            default: nxt = 1;
        endcase
        if (ns_sel == 3'd4) begin
            if (moc) begin
                nxt    = inc;
                m_wait = 0;
            end else if (m_wait == 255) begin
                nxt    = 43;
                m_to   = 1;
                m_wait = 0;
            end else begin
                nxt    = m_state;
                m_wait = m_wait + 1;
            end
        end else begin
            m_wait = 0;
        end
        m_state = nxt;
    endtask

    task automatic cw(input logic [2:0] ns, input logic [1:0] cs, input logic iv,
                      input logic [AW-1:0] cra);
        ns_sel   = ns;
        cond_sel = cs;
        inv      = iv;
        cr_addr  = cra;
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check(tag, 32'(next_state), 32'(m_state));
        check({tag, "_to"}, 32'(mem_timeout), 32'(m_to));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check({tag, "_state"}, 32'(next_state), 32'(m_state));
        check({tag, "_to"}, 32'(mem_timeout), 32'(m_to));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cw(3'd0, 2'd0, 1'b0, '0);
        decode_state = '0;
        cond_in      = 1'b0;
        moc          = 1'b0;
        irq          = 1'b0;
        stall        = 1'b0;
        model_reset();
        do_reset("rst0");

        // State 0 increments, state 1 fetches: expect 1,1,1.
        for (int i = 0; i < 3; i++) begin
            cw((m_state == 0) ? 3'd0 : 3'd7, 2'd0, 1'b0, '0);
            step("fetch_seq");
        end
        check("fetch_seq_final", 32'(next_state), 32'd1);

        // Address wrap.
        cw(3'd1, 2'd0, 1'b0, 10'd1023); step("jump_1023");
        cw(3'd0, 2'd0, 1'b0, '0);       step("inc_wrap");
        check("wrap_zero", 32'(next_state), 32'd0);

        // Decode dispatch.
        decode_state = 10'd77;
        cw(3'd2, 2'd0, 1'b0, '0);       step("decode");

        // Conditional branch, all sources and both polarities.
        cond_in = 1'b1;
        cw(3'd3, 2'd0, 1'b0, 10'd20);   step("cond_taken");
        check("cond_taken_20", 32'(next_state), 32'd20);
        cw(3'd3, 2'd0, 1'b1, 10'd20);   step("cond_inv_fall");
        check("cond_inv_21", 32'(next_state), 32'd21);
        cond_in = 1'b0; irq = 1'b1;
        cw(3'd3, 2'd2, 1'b0, 10'd200);  step("cond_irq");
        cw(3'd3, 2'd1, 1'b0, 10'd300);  step("cond_moc_low");
        cw(3'd3, 2'd3, 1'b1, 10'd400);  step("cond_const_inv");
        cw(3'd3, 2'd3, 1'b0, 10'd400);  step("cond_const");
        irq = 1'b0;

        // Call / return, including overwrite of the single-level return.
        cw(3'd1, 2'd0, 1'b0, 10'd12);   step("jump_12");
        cw(3'd5, 2'd0, 1'b0, 10'd30);   step("call_30");
        cw(3'd6, 2'd0, 1'b0, '0);       step("ret_13");
        check("ret_to_13", 32'(next_state), 32'd13);
        cw(3'd1, 2'd0, 1'b0, 10'd31);   step("jump_31");
        cw(3'd5, 2'd0, 1'b0, 10'd60);   step("call_60");
        cw(3'd5, 2'd0, 1'b0, 10'd90);   step("call_90");
        cw(3'd6, 2'd0, 1'b0, '0);       step("ret_61");
        check("ret_to_61", 32'(next_state), 32'd61);

        // Reset mid-call discards the return address.
        cw(3'd5, 2'd0, 1'b0, 10'd500);  step("call_500");
        do_reset("rst_call");
        cw(3'd6, 2'd0, 1'b0, '0);       step("ret_after_rst");
        check("ret_after_rst_0", 32'(next_state), 32'd0);

        // MOC wait that expires.
        cw(3'd1, 2'd0, 1'b0, 10'd3);    step("jump_3");
        moc = 1'b0;
        cw(3'd4, 2'd0, 1'b0, '0);
        for (int i = 0; i < 255; i++) step("wait_hold");
        check("wait_hold_3", 32'(next_state), 32'd3);
        step("wait_timeout");
        check("timeout_state_43", 32'(next_state), 32'd43);
        check("timeout_flag", 32'(mem_timeout), 32'd1);
        cw(3'd1, 2'd0, 1'b0, 10'd8);    step("sticky_to");

        // MOC arriving on the last permissible cycle wins.
        do_reset("rst_to");
        cw(3'd1, 2'd0, 1'b0, 10'd3);    step("jump_3b");
        cw(3'd4, 2'd0, 1'b0, '0);
        for (int i = 0; i < 255; i++) step("wait_hold_b");
        moc = 1'b1;                     step("wait_moc_wins");
        check("moc_wins_4", 32'(next_state), 32'd4);
        check("moc_wins_noto", 32'(mem_timeout), 32'd0);
        moc = 1'b0;

        // Stall in the middle of a wait freezes the counter.
        cw(3'd1, 2'd0, 1'b0, 10'd3);    step("jump_3c");
        cw(3'd4, 2'd0, 1'b0, '0);
        for (int i = 0; i < 100; i++) step("wait_pre");
        stall = 1'b1;
        for (int i = 0; i < 5; i++) step("wait_stall");
        stall = 1'b0;
        for (int i = 0; i < 155; i++) step("wait_post");
        check("stall_hold_3", 32'(next_state), 32'd3);
        step("stall_timeout");
        check("stall_timeout_43", 32'(next_state), 32'd43);

        // Stall blocks a call from loading the return register.
        cw(3'd5, 2'd0, 1'b0, 10'd600);  step("call_600");
        stall = 1'b1;
        cw(3'd5, 2'd0, 1'b0, 10'd700);  step("call_stalled");
        stall = 1'b0;
        cw(3'd6, 2'd0, 1'b0, '0);       step("ret_44");
        check("ret_to_44", 32'(next_state), 32'd44);

        // Asynchronous reset in the middle of a stall, before any edge.
        stall = 1'b1;
        step("stall_hold");
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_rst_state", 32'(next_state), 32'd0);
        check("async_rst_to", 32'(mem_timeout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;

        // Randomized control words.
        for (int i = 0; i < 400; i++) begin
            ns_sel       = 3'($urandom_range(7, 0));
            cond_sel     = 2'($urandom_range(3, 0));
            inv          = 1'($urandom_range(1, 0));
            cr_addr      = AW'($urandom_range(MOD - 1, 0));
            decode_state = AW'($urandom_range(MOD - 1, 0));
            cond_in      = 1'($urandom_range(1, 0));
            moc          = 1'($urandom_range(1, 0));
            irq          = 1'($urandom_range(1, 0));
            stall        = ($urandom_range(3, 0) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
